// File: rtl/axi4_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register bank.
//   resp_t      : AXI response encoding (OKAY / EXOKAY / SLVERR / DECERR)
//   wr_state_t  : write-channel FSM states
//   rd_state_t  : read-channel FSM states
//   idx_width   : register-index width for a given register count (min 1)
//   strb_merge  : byte-strobe merge of new data into an old word (up to 64 bits)
package axi4_lite_pkg;

    localparam int MAX_DATA_W = 64;
    localparam int MAX_STRB_W = MAX_DATA_W / 8;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_EXEC,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

    function automatic int idx_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    // Bytes with a set strobe take the new data; the rest keep the old value.
    function automatic logic [MAX_DATA_W-1:0] strb_merge(
        input logic [MAX_DATA_W-1:0] old_val,
        input logic [MAX_DATA_W-1:0] data,
        input logic [MAX_STRB_W-1:0] strb
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_val;
        for (int b = 0; b < MAX_STRB_W; b++) begin
            if (strb[b]) begin
                merged[b*8 +: 8] = data[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// Byte address -> register index decode.
//   addr     in  ADDR_W       byte address (low alignment bits ignored)
//   idx      out IDX_W        register index
//   in_range out 1            full word index is below REG_COUNT
//   ro       out 1            in range and the register is read-only
module axi4_lite_addr_decode
    import axi4_lite_pkg::*;
#(
    parameter int                   ADDR_W    = 32,
    parameter int                   DATA_W    = 32,
    parameter int                   REG_COUNT = 16,
    parameter logic [REG_COUNT-1:0] RO_MASK   = '0
) (
    input  logic [ADDR_W-1:0]                 addr,
    output logic [idx_width(REG_COUNT)-1:0]   idx,
    output logic                              in_range,
    output logic                              ro
);

    localparam int AL     = $clog2(DATA_W / 8);
    localparam int IDX_W  = idx_width(REG_COUNT);
    localparam int WORD_W = ADDR_W - AL;

    logic [WORD_W-1:0] word_idx;
    logic              unused_lsb;

    // The range check uses every address bit above the alignment bits, so
    // addresses past the bank never alias onto a low register.
    assign word_idx   = addr[ADDR_W-1:AL];
    assign in_range   = word_idx < WORD_W'(REG_COUNT);
    assign idx        = word_idx[IDX_W-1:0];
    assign ro         = in_range && RO_MASK[idx];
    assign unused_lsb = &{1'b0, addr[AL-1:0]};

endmodule

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave control/status register bank.
//   ACLK/ARESET         clock, synchronous active-high reset
//   AW*/W*/B*           write address, data and response channels
//   AR*/R*              read address and data channels
//   reg_o               all register contents, reg k at [k*DATA_W +: DATA_W]
//   wr_pulse_o          one-cycle pulse per register after a committed write
//   stat_i              live status words returned by read-only registers
// Write and read channels run independent FSMs and never stall each other.
module axi4_lite_regfile
    import axi4_lite_pkg::*;
#(
    parameter int                   ADDR_W    = 32,
    parameter int                   DATA_W    = 32,
    parameter int                   REG_COUNT = 16,
    parameter logic [REG_COUNT-1:0] RO_MASK   = '0
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [ADDR_W-1:0]             AWADDR,
    input  logic [2:0]                    AWPROT,
    input  logic                          WVALID,
    output logic                          WREADY,
    input  logic [DATA_W-1:0]             WDATA,
    input  logic [DATA_W/8-1:0]           WSTRB,
    output logic                          BVALID,
    input  logic                          BREADY,
    output logic [1:0]                    BRESP,
    input  logic                          ARVALID,
    output logic                          ARREADY,
    input  logic [ADDR_W-1:0]             ARADDR,
    input  logic [2:0]                    ARPROT,
    output logic                          RVALID,
    input  logic                          RREADY,
    output logic [DATA_W-1:0]             RDATA,
    output logic [1:0]                    RRESP,
    output logic [REG_COUNT*DATA_W-1:0]   reg_o,
    output logic [REG_COUNT-1:0]          wr_pulse_o,
    input  logic [REG_COUNT*DATA_W-1:0]   stat_i
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = idx_width(REG_COUNT);

    wr_state_t             wr_state_reg, wr_state_next;
    rd_state_t             rd_state_reg, rd_state_next;
    logic                  ready_en_reg;
    logic                  aw_held_reg, w_held_reg;
    logic [ADDR_W-1:0]     awaddr_reg;
    logic [DATA_W-1:0]     wdata_reg;
    logic [STRB_W-1:0]     wstrb_reg;
    resp_t                 bresp_reg;
    logic [REG_COUNT-1:0]  wr_pulse_reg;
    logic [DATA_W-1:0]     rdata_reg;
    resp_t                 rresp_reg;

    logic [DATA_W-1:0]     regs     [REG_COUNT];
    logic [DATA_W-1:0]     stat_arr [REG_COUNT];

    logic                  aw_hs, w_hs, ar_hs, wr_commit;
    logic [IDX_W-1:0]      aw_idx, ar_idx;
    logic                  aw_in_range, aw_ro, ar_in_range, ar_ro;
    logic [MAX_DATA_W-1:0] merged_full;
    logic [DATA_W-1:0]     wr_merged;
    logic [DATA_W-1:0]     rd_data_next;
    logic                  unused_ok;

    axi4_lite_addr_decode #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_COUNT(REG_COUNT), .RO_MASK(RO_MASK)
    ) u_aw_decode (
        .addr(awaddr_reg), .idx(aw_idx), .in_range(aw_in_range), .ro(aw_ro)
    );

    axi4_lite_addr_decode #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_COUNT(REG_COUNT), .RO_MASK(RO_MASK)
    ) u_ar_decode (
        .addr(ARADDR), .idx(ar_idx), .in_range(ar_in_range), .ro(ar_ro)
    );

    // ready_en_reg keeps every READY low on the first cycle after reset.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
        end
    end

    assign AWREADY = ready_en_reg && (wr_state_reg == W_IDLE) && !aw_held_reg;
    assign WREADY  = ready_en_reg && (wr_state_reg == W_IDLE) && !w_held_reg;
    assign ARREADY = ready_en_reg && (rd_state_reg == R_IDLE);
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;
    assign ar_hs   = ARVALID && ARREADY;

    // ---------------- write channel ----------------
    always_comb begin
        wr_state_next = wr_state_reg;
        BVALID        = 1'b0;
        case (wr_state_reg)
            W_IDLE: begin
                // AW and W may arrive in either order; go as soon as both exist.
                if ((aw_held_reg || aw_hs) && (w_held_reg || w_hs)) begin
                    wr_state_next = W_EXEC;
                end
            end
            W_EXEC: wr_state_next = W_RESP;
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) begin
                    wr_state_next = W_IDLE;
                end
            end
            default: wr_state_next = W_IDLE;
        endcase
    end

    assign wr_commit   = (wr_state_reg == W_EXEC) && aw_in_range && !aw_ro;
    assign merged_full = strb_merge(MAX_DATA_W'(regs[aw_idx]), MAX_DATA_W'(wdata_reg),
                                    MAX_STRB_W'(wstrb_reg));
    assign wr_merged   = merged_full[DATA_W-1:0];

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_reg <= W_IDLE;
            aw_held_reg  <= 1'b0;
            w_held_reg   <= 1'b0;
            awaddr_reg   <= '0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            bresp_reg    <= OKAY;
            wr_pulse_reg <= '0;
        end else begin
            wr_state_reg <= wr_state_next;
            if (aw_hs) begin
                aw_held_reg <= 1'b1;
                awaddr_reg  <= AWADDR;
            end
            if (w_hs) begin
                w_held_reg <= 1'b1;
                wdata_reg  <= WDATA;
                wstrb_reg  <= WSTRB;
            end
            if ((wr_state_reg == W_RESP) && BREADY) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
            end
            wr_pulse_reg <= '0;
            if (wr_state_reg == W_EXEC) begin
                bresp_reg <= wr_commit ? OKAY : SLVERR;
                // The pulse fires even when WSTRB is all zero.
                if (wr_commit) begin
                    wr_pulse_reg <= REG_COUNT'(1) << aw_idx;
                end
            end
        end
    end

    assign BRESP      = bresp_reg;
    assign wr_pulse_o = wr_pulse_reg;

    // ---------------- register storage ----------------
    genvar gi;
    generate
        for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
            assign stat_arr[gi] = stat_i[gi*DATA_W +: DATA_W];
            if (RO_MASK[gi]) begin : g_ro
                assign regs[gi] = '0;
            end else begin : g_rw
                logic [DATA_W-1:0] value_reg;
                always_ff @(posedge ACLK) begin
                    if (ARESET) begin
                        value_reg <= '0;
                    end else if (wr_commit && (aw_idx == IDX_W'(gi))) begin
                        value_reg <= wr_merged;
                    end
                end
                assign regs[gi] = value_reg;
            end
            assign reg_o[gi*DATA_W +: DATA_W] = regs[gi];
        end
    endgenerate

    // ---------------- read channel ----------------
    always_comb begin
        rd_state_next = rd_state_reg;
        RVALID        = 1'b0;
        case (rd_state_reg)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_state_next = R_RESP;
                end
            end
            R_RESP: begin
                RVALID = 1'b1;
                if (RREADY) begin
                    rd_state_next = R_IDLE;
                end
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    // Sampled from the current register values, so a read landing on the
    // same edge as a write commit returns the pre-write contents.
    assign rd_data_next = !ar_in_range ? '0 :
                          ar_ro        ? stat_arr[ar_idx] : regs[ar_idx];

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state_reg <= R_IDLE;
            rdata_reg    <= '0;
            rresp_reg    <= OKAY;
        end else begin
            rd_state_reg <= rd_state_next;
            if (ar_hs) begin
                rdata_reg <= rd_data_next;
                rresp_reg <= ar_in_range ? OKAY : SLVERR;
            end
        end
    end

    assign RDATA = rdata_reg;
    assign RRESP = rresp_reg;

    // Protection bits carry no meaning here; upper merge bits only matter at 64-bit width.
    assign unused_ok = &{1'b0, AWPROT, ARPROT, merged_full};

endmodule

// File: tb/tb_axi4_lite_regfile.sv
module tb_axi4_lite_regfile;

    localparam int          ADDR_W    = 32;
    localparam int          DATA_W    = 32;
    localparam int          REG_COUNT = 16;
    localparam logic [15:0] RO_MASK_P = 16'h0008;

    logic                 clk = 1'b0;
    logic                 ARESET, AWVALID, WVALID, BREADY, ARVALID, RREADY;
    logic                 AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [ADDR_W-1:0]    AWADDR, ARADDR;
    logic [2:0]           AWPROT, ARPROT;
    logic [DATA_W-1:0]    WDATA, RDATA;
    logic [3:0]           WSTRB;
    logic [1:0]           BRESP, RRESP;
    logic [511:0]         reg_o, stat_i;
    logic [15:0]          wr_pulse_o;

    always #5 clk = ~clk;

    axi4_lite_regfile #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_COUNT(REG_COUNT), .RO_MASK(RO_MASK_P)
    ) dut (
        .ACLK(clk), .ARESET(ARESET),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .reg_o(reg_o), .wr_pulse_o(wr_pulse_o), .stat_i(stat_i)
    );

    // Behavioural model: register contents plus expected channel outputs
    logic [31:0] model_regs [16];
    logic [15:0] ro_mask_v;
    logic        exp_awready, exp_wready, exp_arready, exp_bvalid, exp_rvalid;
    logic [1:0]  exp_bresp, exp_rresp;
    logic [31:0] exp_rdata;
    logic [15:0] exp_pulse;
    bit          chk_en = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("awready", 64'(AWREADY), 64'(exp_awready));
            chk("wready", 64'(WREADY), 64'(exp_wready));
            chk("arready", 64'(ARREADY), 64'(exp_arready));
            chk("bvalid", 64'(BVALID), 64'(exp_bvalid));
            chk("rvalid", 64'(RVALID), 64'(exp_rvalid));
            chk("wr_pulse", 64'(wr_pulse_o), 64'(exp_pulse));
            if (exp_bvalid) chk("bresp", 64'(BRESP), 64'(exp_bresp));
            if (exp_rvalid) begin
                chk("rdata", 64'(RDATA), 64'(exp_rdata));
                chk("rresp", 64'(RRESP), 64'(exp_rresp));
            end
            for (int k = 0; k < 16; k++) begin
                chk($sformatf("reg%0d", k), 64'(reg_o[k*32 +: 32]), 64'(model_regs[k]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0; BREADY = 1'b0; RREADY = 1'b0;
        tick();
        ARESET = 1'b0;
        for (int k = 0; k < 16; k++) model_regs[k] = 32'h0;
        exp_awready = 1'b0; exp_wready = 1'b0; exp_arready = 1'b0;
        exp_bvalid = 1'b0; exp_rvalid = 1'b0; exp_pulse = 16'h0;
        exp_bresp = 2'b00; exp_rresp = 2'b00; exp_rdata = 32'h0;
        chk_en = 1'b1;
        chk("rst_rdata", 64'(RDATA), 64'h0);
        chk("rst_bresp", 64'(BRESP), 64'h0);
        chk("rst_rresp", 64'(RRESP), 64'h0);
        tick();
        exp_awready = 1'b1; exp_wready = 1'b1; exp_arready = 1'b1;
    endtask

    // One write transaction; b_dly < 0 aborts it with a reset while BVALID is up.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly, output logic [1:0] got_resp);
        bit          aw_done, w_done, err;
        int          idx;
        logic [31:0] nv;
        aw_done = 1'b0;
        w_done  = 1'b0;
        got_resp = 2'bxx;
        idx = int'(addr >> 2);
        err = (idx >= 16) ? 1'b1 : ro_mask_v[idx];
        for (int k = 0; k <= aw_dly + w_dly + 1; k++) begin
            if (aw_done && w_done) break;
            AWVALID = !aw_done && (k >= aw_dly);
            AWADDR  = addr;
            AWPROT  = 3'b010;
            WVALID  = !w_done && (k >= w_dly);
            WDATA   = data;
            WSTRB   = strb;
            exp_awready = !aw_done;
            exp_wready  = !w_done;
            tick();
            if (AWVALID) aw_done = 1'b1;
            if (WVALID)  w_done  = 1'b1;
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        exp_awready = 1'b0; exp_wready = 1'b0;
        tick();
        if (!err) begin
            nv = model_regs[idx];
            for (int b = 0; b < 4; b++) if (strb[b]) nv[8*b +: 8] = data[8*b +: 8];
            model_regs[idx] = nv;
            exp_pulse = 16'h0;
            exp_pulse[idx] = 1'b1;
        end
        exp_bvalid = 1'b1;
        exp_bresp  = err ? 2'b10 : 2'b00;
        got_resp   = BRESP;
        if (b_dly < 0) begin
            tick();
            exp_pulse = 16'h0;
            tick();
            do_reset();
        end else begin
            for (int k = 0; k <= b_dly; k++) begin
                BREADY = (k >= b_dly);
                tick();
                exp_pulse = 16'h0;
                if (BREADY) break;
            end
            BREADY = 1'b0;
            exp_bvalid = 1'b0; exp_awready = 1'b1; exp_wready = 1'b1;
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                           output logic [31:0] got_data, output logic [1:0] got_resp);
        int idx;
        for (int k = 0; k < ar_dly; k++) begin
            exp_arready = 1'b1;
            tick();
        end
        ARVALID = 1'b1;
        ARADDR  = addr;
        ARPROT  = 3'b000;
        exp_arready = 1'b1;
        #1;
        idx = int'(addr >> 2);
        if (idx >= 16) begin
            exp_rdata = 32'h0; exp_rresp = 2'b10;
        end else if (ro_mask_v[idx]) begin
            exp_rdata = stat_i[idx*32 +: 32]; exp_rresp = 2'b00;
        end else begin
            exp_rdata = model_regs[idx]; exp_rresp = 2'b00;
        end
        tick();
        ARVALID = 1'b0;
        exp_arready = 1'b0;
        exp_rvalid  = 1'b1;
        got_data = RDATA;
        got_resp = RRESP;
        for (int k = 0; k <= r_dly; k++) begin
            RREADY = (k >= r_dly);
            tick();
            if (RREADY) break;
        end
        RREADY = 1'b0;
        exp_rvalid = 1'b0; exp_arready = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  br, rr;
        logic [31:0] rd;
        ro_mask_v = RO_MASK_P;
        AWADDR = '0; ARADDR = '0; WDATA = '0; WSTRB = '0; AWPROT = '0; ARPROT = '0;
        stat_i = '0;
        stat_i[31:0] = 32'hFFFF_FFFF;           // status for an RW register: must be ignored
        do_reset();

        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, br);
        chk("t1_bresp", 64'(br), 64'h0);
        chk("t1_reg1", 64'(reg_o[63:32]), 64'hDEADBEEF);

        do_write(32'h08, 32'hAABBCCDD, 4'b0101, 3, 0, 1, br);
        chk("t2_bresp", 64'(br), 64'h0);
        chk("t2_reg2", 64'(reg_o[95:64]), 64'h00BB00DD);

        do_write(32'h40, 32'h1234_0000, 4'hF, 0, 2, 0, br);
        chk("t3_oor_bresp", 64'(br), 64'h2);
        do_write(32'h0C, 32'hCAFEF00D, 4'hF, 1, 1, 2, br);
        chk("t3_ro_bresp", 64'(br), 64'h2);
        chk("t3_reg3", 64'(reg_o[127:96]), 64'h0);

        do_write(32'h10, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, br);
        chk("t4_strb0_bresp", 64'(br), 64'h0);
        chk("t4_reg4", 64'(reg_o[159:128]), 64'h0);
        do_write(32'h07, 32'h0000_5500, 4'b0010, 0, 0, 0, br);
        chk("t4_unaligned_reg1", 64'(reg_o[63:32]), 64'hDEAD55EF);
        do_write(32'h3C, 32'h0F0F_0F0F, 4'hF, 2, 0, 0, br);
        chk("t4_reg15", 64'(reg_o[511:480]), 64'h0F0F0F0F);

        do_read(32'h40, 0, 0, rd, rr);
        chk("t5_oor_rdata", 64'(rd), 64'h0);
        chk("t5_oor_rresp", 64'(rr), 64'h2);
        stat_i[127:96] = 32'h12345678;
        do_read(32'h0C, 0, 5, rd, rr);
        chk("t5_ro_rdata", 64'(rd), 64'h12345678);
        chk("t5_ro_rresp", 64'(rr), 64'h0);
        do_read(32'h00, 1, 0, rd, rr);
        chk("t5_reg0_rdata", 64'(rd), 64'h0);
        do_read(32'h08, 0, 1, rd, rr);
        chk("t5_reg2_rdata", 64'(rd), 64'h00BB00DD);

        do_write(32'h04, 32'h11, 4'hF, 0, 0, 0, br);
        fork
            begin
                do_write(32'h04, 32'h22, 4'hF, 0, 0, 0, br);
            end
            begin
                do_read(32'h04, 1, 0, rd, rr);
            end
        join
        chk("t6_old_rdata", 64'(rd), 64'h11);
        do_read(32'h04, 0, 0, rd, rr);
        chk("t6_new_rdata", 64'(rd), 64'h22);

        do_write(32'h14, 32'h55AA, 4'hF, 0, 0, -1, br);
        for (int k = 0; k < 4; k++) tick();
        chk("t7_reg1_cleared", 64'(reg_o[63:32]), 64'h0);
        chk("t7_reg5_cleared", 64'(reg_o[191:160]), 64'h0);
        do_read(32'h04, 0, 0, rd, rr);
        chk("t7_read_after_reset", 64'(rd), 64'h0);
        do_write(32'h18, 32'hA5A5_5A5A, 4'hF, 0, 1, 0, br);
        chk("t7_write_after_reset", 64'(reg_o[223:192]), 64'hA5A55A5A);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
